// File: rtl/dma_priority_resolver_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared types and helpers for the 8237A-style DMA priority resolver.
//   pr_state_t    : resolver state (IDLE / REQ / SERVICE)
//   pick_t        : arbitration result (valid flag + 2-bit channel index)
//   priorityPick  : fixed or rotating priority selection over 4 channels
//   ch_onehot     : 2-bit channel index to 4-bit one-hot vector
// -----------------------------------------------------------------------------
package dma_pkg;

  localparam int DMA_NUM_CH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } pr_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } pick_t;

  // Highest priority is channel 0 in fixed mode, or the channel after the
  // last serviced one in rotating mode. Scanning from the lowest priority
  // upward lets the highest-priority pending channel overwrite the result last.
  function automatic pick_t priorityPick(input logic [3:0] pending,
                                         input logic [1:0] lastServiced,
                                         input logic       rotating);
    pick_t      res;
    logic [1:0] start;
    logic [1:0] cand;
    res.valid = 1'b0;
    res.idx   = 2'd0;
    if (rotating) begin
      start = lastServiced + 2'd1;
    end else begin
      start = 2'd0;
    end
    for (int i = 3; i >= 0; i--) begin
      cand = start + 2'(i);
      if (pending[cand]) begin
        res.valid = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] ch_onehot(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/dma_priority_resolver_if.sv
// -----------------------------------------------------------------------------
// dma_priority_resolver_if
// Bundles the priority resolver's request, command and Timing-and-Control
// handshake signals.
//   master : request/command source side (datapath, pins, TC)
//   slave  : the priority resolver itself
// Signals:
//   DREQ[3:0], softReq[3:0], mask[3:0]          request sources and mask
//   controllerDisable, rotatingPriority,
//   dreqSenseLow, dackSenseHigh                  command register bits
//   hrq, validDACK                               from Timing and Control
//   VALID_DREQ0..3, activeCh[1:0]                granted request to TC
//   DACK[3:0], clrSoftReq[3:0]                   acknowledge pins, soft clear
// -----------------------------------------------------------------------------
interface dma_priority_resolver_if;
  import dma_pkg::*;

  logic [DMA_NUM_CH-1:0] DREQ;
  logic [DMA_NUM_CH-1:0] softReq;
  logic [DMA_NUM_CH-1:0] mask;
  logic                  controllerDisable;
  logic                  rotatingPriority;
  logic                  dreqSenseLow;
  logic                  dackSenseHigh;
  logic                  hrq;
  logic                  validDACK;
  logic                  VALID_DREQ0;
  logic                  VALID_DREQ1;
  logic                  VALID_DREQ2;
  logic                  VALID_DREQ3;
  logic [DMA_NUM_CH-1:0] DACK;
  logic [1:0]            activeCh;
  logic [DMA_NUM_CH-1:0] clrSoftReq;

  modport master (
    output DREQ, softReq, mask, controllerDisable, rotatingPriority,
           dreqSenseLow, dackSenseHigh, hrq, validDACK,
    input  VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3,
           DACK, activeCh, clrSoftReq
  );

  modport slave (
    input  DREQ, softReq, mask, controllerDisable, rotatingPriority,
           dreqSenseLow, dackSenseHigh, hrq, validDACK,
    output VALID_DREQ0, VALID_DREQ1, VALID_DREQ2, VALID_DREQ3,
           DACK, activeCh, clrSoftReq
  );

endinterface

// File: rtl/dma_priority_resolver_dreq_sync.sv
// -----------------------------------------------------------------------------
// dma_dreq_sync
// Samples the four raw DREQ pins into the CLK domain.
// Build option DMA_DREQ_SYNC_EN:
//   defined   : two-flop synchronizer (pins may be asynchronous to CLK)
//   undefined : single sample register (pins already synchronous to CLK)
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   d      in   raw DREQ pins
//   q      out  sampled DREQ
// -----------------------------------------------------------------------------
module dma_dreq_sync
  import dma_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DMA_NUM_CH-1:0] d,
  output logic [DMA_NUM_CH-1:0] q
);

`ifdef DMA_DREQ_SYNC_EN
  logic [DMA_NUM_CH-1:0] meta_r;
  logic [DMA_NUM_CH-1:0] sync_r;

  // Two-stage synchronizer chain for asynchronous request pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 4'b0000;
      sync_r <= 4'b0000;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;
`else
  logic [DMA_NUM_CH-1:0] sample_r;

  // Single sample register for request pins already synchronous to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_r <= 4'b0000;
    end else begin
      sample_r <= d;
    end
  end

  assign q = sample_r;
`endif

endmodule

// File: rtl/dma_priority_resolver.sv
// -----------------------------------------------------------------------------
// dma_priority_resolver
// Priority Resolver of an 8237A-style DMA controller. Combines synchronized
// DREQ pins and software requests, applies mask / polarity / controller
// disable, selects one channel by fixed or rotating priority, presents it to
// Timing and Control as a one-hot VALID_DREQ, holds it through service, drives
// DACK, and updates the rotating-priority pointer when service ends.
// Build option DMA_DREQ_SYNC_EN selects the two-flop DREQ synchronizer
// (pin-to-VALID latency 3 CLK) instead of a single sample (latency 2 CLK).
// Ports:
//   CLK    in   system clock
//   RESET  in   asynchronous active-low reset
//   bus    slave modport of dma_priority_resolver_if (requests, command bits,
//          hrq/validDACK in; VALID_DREQ0..3, DACK, activeCh, clrSoftReq out)
// -----------------------------------------------------------------------------
module dma_priority_resolver
  import dma_pkg::*;
#(
  parameter int         NUM_CH              = DMA_NUM_CH,
  parameter logic [1:0] RESET_LAST_SERVICED = 2'd3
) (
  input  logic                   CLK,
  input  logic                   RESET,
  dma_priority_resolver_if.slave bus
);

  logic [NUM_CH-1:0] dreq_sync_s;
  logic [NUM_CH-1:0] hw_req_s;
  logic [NUM_CH-1:0] pending_s;
  logic [NUM_CH-1:0] arb_req_s;
  pick_t             pick_s;
  logic [NUM_CH-1:0] dack_active_s;
  logic [NUM_CH-1:0] dack_inactive_s;

  pr_state_t         state_r;
  pr_state_t         state_next_s;
  logic [NUM_CH-1:0] valid_r;
  logic [NUM_CH-1:0] valid_next_s;
  logic [1:0]        active_r;
  logic [1:0]        active_next_s;
  logic [NUM_CH-1:0] dack_r;
  logic [NUM_CH-1:0] dack_next_s;
  logic [NUM_CH-1:0] clr_r;
  logic [NUM_CH-1:0] clr_next_s;
  logic [1:0]        last_r;
  logic [1:0]        last_next_s;

  dma_dreq_sync u_dreq_sync (
    .clk   (CLK),
    .rst_n (RESET),
    .d     (bus.DREQ),
    .q     (dreq_sync_s)
  );

  assign hw_req_s  = dreq_sync_s ^ {NUM_CH{bus.dreqSenseLow}};
  assign pending_s = ((hw_req_s & ~bus.mask) | bus.softReq)
                     & {NUM_CH{~bus.controllerDisable}};

  // While clrSoftReq is pulsing, the datapath has not yet cleared the
  // serviced softReq bit; keep that stale bit out of the next arbitration.
  assign arb_req_s = pending_s & ~clr_r;
  assign pick_s    = priorityPick(arb_req_s, last_r, bus.rotatingPriority);

  assign dack_active_s   = bus.dackSenseHigh ? ch_onehot(active_r)
                                             : ~ch_onehot(active_r);
  assign dack_inactive_s = {NUM_CH{~bus.dackSenseHigh}};

  // State and registered outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r  <= IDLE;
      valid_r  <= 4'b0000;
      active_r <= 2'd0;
      dack_r   <= 4'b1111;
      clr_r    <= 4'b0000;
      last_r   <= RESET_LAST_SERVICED;
    end else begin
      state_r  <= state_next_s;
      valid_r  <= valid_next_s;
      active_r <= active_next_s;
      dack_r   <= dack_next_s;
      clr_r    <= clr_next_s;
      last_r   <= last_next_s;
    end
  end

  // Next-state decode. A granted channel is frozen in REQ; only withdrawal
  // (request gone with no hrq yet), controller disable or validDACK move it.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_s.valid) begin
          state_next_s = REQ;
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        if (bus.controllerDisable) begin
          state_next_s = IDLE;
        end else if (bus.validDACK) begin
          state_next_s = SERVICE;
        end else if (!pending_s[active_r] && !bus.hrq) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = REQ;
        end
      end
      SERVICE: begin
        if (!bus.validDACK) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = SERVICE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Next values of the registered outputs, keyed on the current state and
  // the transition chosen above.
  always_comb begin
    valid_next_s  = valid_r;
    active_next_s = active_r;
    dack_next_s   = dack_inactive_s;
    clr_next_s    = 4'b0000;
    last_next_s   = last_r;
    case (state_r)
      IDLE: begin
        if (pick_s.valid) begin
          active_next_s = pick_s.idx;
          valid_next_s  = ch_onehot(pick_s.idx);
        end else begin
          valid_next_s  = 4'b0000;
        end
      end
      REQ: begin
        if (state_next_s == IDLE) begin
          valid_next_s = 4'b0000;
        end else if (state_next_s == SERVICE) begin
          dack_next_s  = dack_active_s;
        end else begin
          valid_next_s = valid_r;
        end
      end
      SERVICE: begin
        if (state_next_s == IDLE) begin
          valid_next_s = 4'b0000;
          last_next_s  = active_r;
          clr_next_s   = ch_onehot(active_r) & bus.softReq;
        end else begin
          dack_next_s  = dack_active_s;
        end
      end
      default: begin
        valid_next_s = 4'b0000;
      end
    endcase
  end

  assign bus.VALID_DREQ0 = valid_r[0];
  assign bus.VALID_DREQ1 = valid_r[1];
  assign bus.VALID_DREQ2 = valid_r[2];
  assign bus.VALID_DREQ3 = valid_r[3];
  assign bus.DACK        = dack_r;
  assign bus.activeCh    = active_r;
  assign bus.clrSoftReq  = clr_r;

endmodule

// File: tb/tb_dma_priority_resolver.sv
module tb_dma_priority_resolver;

`ifdef DMA_DREQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic CLK;
  logic RESET;

  dma_priority_resolver_if pr_if ();

  dma_priority_resolver dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (pr_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int         last_sv = 3;
  bit         rot_m   = 1'b0;
  bit         dsl     = 1'b0;
  bit         dsh     = 1'b0;
  logic [3:0] dreq_v  = 4'b0000;
  logic [3:0] soft_v  = 4'b0000;
  logic [3:0] mask_v  = 4'b0000;

  int         grant_q[$];
  logic [3:0] clr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] valid_vec();
    return {pr_if.VALID_DREQ3, pr_if.VALID_DREQ2, pr_if.VALID_DREQ1, pr_if.VALID_DREQ0};
  endfunction

  function automatic logic [3:0] model_pending();
    logic [3:0] hw;
    hw = dreq_v ^ {4{dsl}};
    return (hw & ~mask_v) | soft_v;
  endfunction

  // first pending channel walking from the top-priority slot upward
  function automatic int model_winner(input logic [3:0] pend, input int last, input bit rot);
    int start;
    int c;
    start = rot ? (last + 1) % 4 : 0;
    for (int k = 0; k < 4; k++) begin
      c = (start + k) % 4;
      if (pend[c]) return c;
    end
    return -1;
  endfunction

  // monitor: compares every new grant and every clrSoftReq pulse
  logic [3:0] prev_valid = 4'b0000;
  always @(negedge CLK) begin : monitor
    logic [3:0] v;
    int         w;
    logic [3:0] c;
    v = valid_vec();
    if (RESET === 1'b1) begin
      if (v != 4'b0000 && prev_valid == 4'b0000) begin
        if (grant_q.size() == 0) begin
          check("unexpected_grant", v, 4'b0000);
        end else begin
          w = grant_q.pop_front();
          check("grant", v, 4'b0001 << w);
        end
      end
      if (pr_if.clrSoftReq != 4'b0000) begin
        if (clr_q.size() == 0) begin
          check("unexpected_clr", pr_if.clrSoftReq, 4'b0000);
        end else begin
          c = clr_q.pop_front();
          check("clr_pulse", pr_if.clrSoftReq, c);
        end
      end
    end
    prev_valid = v;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_grant(input int w);
    int n;
    n = 0;
    while (valid_vec() == 4'b0000 && n < 12) begin
      tick();
      n++;
    end
    check("grant_vec", valid_vec(), 4'b0001 << w);
    check("active_ch", pr_if.activeCh, w);
  endtask

  task automatic service(input int w, input int n);
    logic [3:0] exp_dack;
    @(negedge CLK);
    pr_if.validDACK = 1'b1;
    pr_if.hrq       = 1'b1;
    dreq_v[w]       = dsl;
    pr_if.DREQ      = dreq_v;
    if (soft_v[w]) clr_q.push_back(4'b0001 << w);
    exp_dack = dsh ? (4'b0001 << w) : ~(4'b0001 << w);
    for (int k = 0; k < n; k++) begin
      tick();
      check("dack_service", pr_if.DACK, exp_dack);
      check("valid_hold", valid_vec(), 4'b0001 << w);
    end
    @(negedge CLK);
    pr_if.validDACK = 1'b0;
    pr_if.hrq       = 1'b0;
    tick();
    check("valid_end", valid_vec(), 4'b0000);
    check("dack_end", pr_if.DACK, {4{~dsh}});
    @(negedge CLK);
    soft_v[w]     = 1'b0;
    pr_if.softReq = soft_v;
    last_sv       = w;
  endtask

  task automatic run_batch();
    logic [3:0] pend;
    int         w;
    pend = model_pending();
    while (pend != 4'b0000) begin
      w = model_winner(pend, last_sv, rot_m);
      grant_q.push_back(w);
      wait_grant(w);
      service(w, $urandom_range(3, 6));
      pend = model_pending();
    end
  endtask

  // pins settle behind a full mask, then mask/soft/priority switch together
  task automatic setup(input logic [3:0] d, input logic [3:0] s, input logic [3:0] m,
                       input bit r, input bit sl, input bit sh);
    @(negedge CLK);
    pr_if.mask          = 4'b1111;
    pr_if.softReq       = 4'b0000;
    dreq_v              = d;
    pr_if.DREQ          = d;
    dsl                 = sl;
    pr_if.dreqSenseLow  = sl;
    dsh                 = sh;
    pr_if.dackSenseHigh = sh;
    repeat (LAT + 1) @(posedge CLK);
    @(negedge CLK);
    mask_v                 = m;
    soft_v                 = s;
    rot_m                  = r;
    pr_if.mask             = m;
    pr_if.softReq          = s;
    pr_if.rotatingPriority = r;
  endtask

  task automatic latency_grant(input logic [3:0] d, input int w);
    @(negedge CLK);
    dreq_v     = d;
    pr_if.DREQ = d;
    grant_q.push_back(w);
    repeat (LAT - 1) tick();
    check("latency_early", valid_vec(), 4'b0000);
    tick();
    check("latency_grant", valid_vec(), 4'b0001 << w);
    check("latency_active", pr_if.activeCh, w);
  endtask

  initial begin
    int n;
    RESET                   = 1'b0;
    pr_if.DREQ              = 4'b0000;
    pr_if.softReq           = 4'b0000;
    pr_if.mask              = 4'b0000;
    pr_if.controllerDisable = 1'b0;
    pr_if.rotatingPriority  = 1'b0;
    pr_if.dreqSenseLow      = 1'b0;
    pr_if.dackSenseHigh     = 1'b0;
    pr_if.hrq               = 1'b0;
    pr_if.validDACK         = 1'b0;
    #12;
    check("reset_valid", valid_vec(), 4'b0000);
    check("reset_dack", pr_if.DACK, 4'b1111);
    check("reset_active", pr_if.activeCh, 2'd0);
    check("reset_clr", pr_if.clrSoftReq, 4'b0000);
    @(negedge CLK);
    RESET = 1'b1;

    // fixed priority, DREQ 1010 -> ch1 after pin latency; then ch3 remains
    latency_grant(4'b1010, 1);
    dsh = 1'b1;
    pr_if.dackSenseHigh = 1'b1;
    service(1, 5);
    run_batch();

    // bring lastServiced to 1, then rotating over all four channels
    setup(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    run_batch();
    setup(4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1);
    run_batch();

    // software request bypasses the mask
    setup(4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1);
    run_batch();

    // withdrawal before grant (hrq low)
    setup(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    grant_q.push_back(0);
    wait_grant(0);
    @(negedge CLK);
    dreq_v = 4'b0000;
    pr_if.DREQ = dreq_v;
    n = 0;
    while (valid_vec() != 4'b0000 && n < 10) begin
      tick();
      n++;
    end
    check("withdraw_clear", valid_vec(), 4'b0000);
    repeat (3) tick();
    check("withdraw_idle", valid_vec(), 4'b0000);

    // request dropped while hrq is high: grant is held
    @(negedge CLK);
    dreq_v = 4'b0001;
    pr_if.DREQ = dreq_v;
    grant_q.push_back(0);
    wait_grant(0);
    @(negedge CLK);
    pr_if.hrq = 1'b1;
    dreq_v = 4'b0000;
    pr_if.DREQ = dreq_v;
    repeat (6) tick();
    check("hrq_hold", valid_vec(), 4'b0001);
    service(0, 3);

    // controller disable while in REQ
    @(negedge CLK);
    dreq_v = 4'b0010;
    pr_if.DREQ = dreq_v;
    grant_q.push_back(1);
    wait_grant(1);
    @(negedge CLK);
    pr_if.controllerDisable = 1'b1;
    pr_if.hrq = 1'b1;
    dreq_v = 4'b0000;
    pr_if.DREQ = dreq_v;
    tick();
    check("cdis_drop", valid_vec(), 4'b0000);
    repeat (LAT + 1) tick();
    @(negedge CLK);
    pr_if.controllerDisable = 1'b0;
    pr_if.hrq = 1'b0;

    // reset in the middle of service
    @(negedge CLK);
    dreq_v = 4'b0001;
    pr_if.DREQ = dreq_v;
    grant_q.push_back(0);
    wait_grant(0);
    @(negedge CLK);
    pr_if.validDACK = 1'b1;
    pr_if.hrq = 1'b1;
    dreq_v = 4'b0000;
    pr_if.DREQ = dreq_v;
    tick();
    check("dack_before_reset", pr_if.DACK, 4'b0001);
    #2;
    RESET = 1'b0;
    #1;
    check("midreset_valid", valid_vec(), 4'b0000);
    check("midreset_dack", pr_if.DACK, 4'b1111);
    check("midreset_active", pr_if.activeCh, 2'd0);
    @(negedge CLK);
    RESET = 1'b1;
    pr_if.validDACK = 1'b0;
    pr_if.hrq = 1'b0;
    last_sv = 3;

    // rotating right after reset: ch0 is on top
    rot_m = 1'b1;
    pr_if.rotatingPriority = 1'b1;
    latency_grant(4'b1001, 0);
    service(0, 3);
    run_batch();

    // DREQ3 alone, fixed priority
    rot_m = 1'b0;
    pr_if.rotatingPriority = 1'b0;
    latency_grant(4'b1000, 3);
    service(3, 3);

    // active-low DREQ: pins 1011 mean only ch2 requests
    setup(4'b1011, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    run_batch();
    setup(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);

    // randomized traffic
    for (int it = 0; it < 12; it++) begin
      setup(4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15) & $urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (model_pending() == 4'b0000) begin
        soft_v[$urandom_range(0, 3)] = 1'b1;
        pr_if.softReq = soft_v;
      end
      run_batch();
    end

    repeat (5) tick();
    check("grant_q_empty", grant_q.size(), 0);
    check("clr_q_empty", clr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
